mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single off-chip memory port between the instruction-cache refill path (fetch) and the data-cache miss path.
- Arbitrates requests each cycle and records which requester owns each outstanding memory transaction tag.
- Routes tagged responses back to the owning requester.
- Drops responses for fetch transactions that were in flight when a branch-misprediction squash occurred, so fetch restarts cleanly at the resolved target.

Parameters:
- TAG_W, 4, width of memory transaction tag; tag 0 means "not accepted / no response"; usable tags 1..2^TAG_W-1.
- MAX_WAIT, 4, number of consecutive cycles fetch may lose arbitration before it is granted priority.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- squash  in  1  misprediction flush from ROB; marks all outstanding fetch transactions stale.
- if_req_valid  in  1  icache requests a 64-bit block load.
- if_req_addr  in  32  block-aligned load address.
- if_req_accept  out  1  request taken by memory this cycle.
- if_resp_valid  out  1  load data for a live fetch transaction.
- if_resp_addr  out  32  address the data belongs to.
- if_resp_data  out  64  block data.
- dc_req_valid  in  1  dcache request.
- dc_req_store  in  1  1 = store, 0 = load.
- dc_req_addr  in  32  block-aligned address.
- dc_req_data  in  64  store data.
- dc_req_accept  out  1  request taken by memory this cycle.
- dc_resp_valid  out  1  load data for a dcache transaction.
- dc_resp_addr  out  32  address the data belongs to.
- dc_resp_data  out  64  block data.
- proc2mem_command  out  2  0 NONE, 1 LOAD, 2 STORE.
- proc2mem_addr  out  32  request address.
- proc2mem_data  out  64  store data.
- mem2proc_transaction_tag  in  TAG_W  tag assigned to this cycle's command; 0 = rejected.
- mem2proc_data  in  64  response data.
- mem2proc_data_tag  in  TAG_W  tag of returning data; 0 = none.

Behaviour:
- Grant is combinational, same cycle.
  - Dcache wins by default.
  - Fetch wins if wait_cnt == MAX_WAIT.
  - A lone requester always wins.
  - The selected request drives proc2mem_*. With no request, command = NONE, addr/data = 0.
- Accept: x_req_accept = granted && mem2proc_transaction_tag != 0. Requesters hold valid and payload until accepted.
- Tag table: 2^TAG_W entries {valid, owner(IF/DC), stale, addr}; entry 0 is never used.
  - Load accept writes entry[tag] at clock edge as valid=1, owner, stale=0, addr.
  - Store accept allocates nothing; stores never generate a response.
- Response routing: if mem2proc_data_tag != 0 and entry valid, same cycle:
  - Owner DC: dc_resp_valid=1.
  - Owner IF and not stale: if_resp_valid=1.
  - Owner IF and stale: response dropped.
  - Entry is cleared at the clock edge in all three cases.
  - Response to an invalid entry is ignored; no output is asserted.
  - resp_data = mem2proc_data; resp_addr = entry.addr.
  - All resp outputs are 0 when not valid.
- Squash:
  - At the clock edge, sets stale=1 on every valid IF entry.
  - The same cycle's if_resp_valid is already suppressed: squash is combinationally ORed into the stale check.
  - An IF request accepted in the squash cycle is also recorded as stale.
  - DC entries are unaffected.
- wait_cnt (saturating at MAX_WAIT):
  - Increments when if_req_valid && !IF granted.
  - Resets to 0 when IF is accepted or if_req_valid=0.
  - Holds when IF is granted but rejected by memory.
- Simultaneous: a response and a new accept may hit the same tag in one cycle. The response clears first, then the new allocate writes; the allocate wins.
- Reset: all table entries invalid, wait_cnt=0. All outputs are combinationally 0 while no inputs are asserted. Reset mid-transaction discards outstanding tags; late responses to them are ignored.

Optional Feature:
- MEM_ARB_STATS_EN: adds outputs if_grant_cnt, dc_grant_cnt, stale_drop_cnt (32 bits each, wrapping).
  - They count accepted IF requests, accepted DC requests, and dropped stale responses.
  - They clear on reset.
- Without the macro these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- IF load addr 0x100 alone, memory tag 3; 5 cycles later data_tag 3, data 0xDEAD -> if_req_accept=1 on cycle 0; if_resp_valid=1, addr 0x100, data 0xDEAD.
- IF and DC both request (DC load 0x200) for 6 cycles, memory always tags -> DC accepted cycles 0-3; IF accepted cycle 4 (wait_cnt hit 4); then DC resumes.
- IF load 0x300 on tag 5, squash asserted 2 cycles later, data_tag 5 returns -> no if_resp_valid; entry 5 freed; stale_drop_cnt=1 with MEM_ARB_STATS_EN.
- DC store 0x400, data 0xBEEF, tag 7 -> command=2, proc2mem_data=0xBEEF, dc_req_accept=1; no table entry; a later data_tag 7 is ignored.
- Memory returns transaction_tag 0 while IF requests -> if_req_accept=0, proc2mem_command stays LOAD, request retried next cycle.
- Reset with tags 2 and 9 outstanding, then data_tag 2 -> no resp_valid on either port.

Source files
------------

// File: rtl/mem_arbiter.sv
// Memory-port arbiter between icache refill (fetch) and dcache miss paths, with tag
// ownership tracking and squash-based dropping of stale fetch responses.
// Optional build macro MEM_ARB_STATS_EN adds grant and stale-drop counters.
module mem_arbiter #(
    parameter int TAG_W    = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash,
    input  logic              if_req_valid,
    input  logic [31:0]       if_req_addr,
    output logic              if_req_accept,
    output logic              if_resp_valid,
    output logic [31:0]       if_resp_addr,
    output logic [63:0]       if_resp_data,
    input  logic              dc_req_valid,
    input  logic              dc_req_store,
    input  logic [31:0]       dc_req_addr,
    input  logic [63:0]       dc_req_data,
    output logic              dc_req_accept,
    output logic              dc_resp_valid,
    output logic [31:0]       dc_resp_addr,
    output logic [63:0]       dc_resp_data,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]       if_grant_cnt,
    output logic [31:0]       dc_grant_cnt,
    output logic [31:0]       stale_drop_cnt,
`endif
    output logic [1:0]        proc2mem_command,
    output logic [31:0]       proc2mem_addr,
    output logic [63:0]       proc2mem_data,
    input  logic [TAG_W-1:0]  mem2proc_transaction_tag,
    input  logic [63:0]       mem2proc_data,
    input  logic [TAG_W-1:0]  mem2proc_data_tag
);

    localparam int NTAGS  = 2 ** TAG_W;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2
    } mem_cmd_e;

    logic [NTAGS-1:0] tbl_valid;
    logic [NTAGS-1:0] tbl_is_if;
    logic [NTAGS-1:0] tbl_stale;
    logic [31:0]      tbl_addr [NTAGS];

    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_sat;
    logic              if_grant;
    logic              dc_grant;
    logic              mem_taken;
    logic              alloc;
    logic [31:0]       alloc_addr;
    logic              rsp_hit;
    logic              rsp_is_if;
    logic              rsp_stale;
    mem_cmd_e          cmd;

    assign wait_sat  = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign mem_taken = (mem2proc_transaction_tag != '0);

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        if_grant      = if_req_valid && (!dc_req_valid || wait_sat);
        dc_grant      = dc_req_valid && !if_grant;
        cmd           = CMD_NONE;
        proc2mem_addr = '0;
        proc2mem_data = '0;
        if (if_grant) begin
            cmd           = CMD_LOAD;
            proc2mem_addr = if_req_addr;
        end else if (dc_grant) begin
            cmd           = dc_req_store ? CMD_STORE : CMD_LOAD;
            proc2mem_addr = dc_req_addr;
            proc2mem_data = dc_req_data;
        end
    end

    assign proc2mem_command = cmd;
    assign if_req_accept    = if_grant && mem_taken;
    assign dc_req_accept    = dc_grant && mem_taken;
    assign alloc            = if_req_accept || (dc_req_accept && !dc_req_store);
    assign alloc_addr       = if_grant ? if_req_addr : dc_req_addr;

    // Squash counts as stale in the same cycle so a response racing the flush is dropped.
    assign rsp_hit   = (mem2proc_data_tag != '0) && tbl_valid[mem2proc_data_tag];
    assign rsp_is_if = tbl_is_if[mem2proc_data_tag];
    assign rsp_stale = tbl_stale[mem2proc_data_tag] || squash;

    always_comb begin
        if_resp_valid = rsp_hit && rsp_is_if && !rsp_stale;
        dc_resp_valid = rsp_hit && !rsp_is_if;
        if_resp_addr  = '0;
        if_resp_data  = '0;
        dc_resp_addr  = '0;
        dc_resp_data  = '0;
        if (if_resp_valid) begin
            if_resp_addr = tbl_addr[mem2proc_data_tag];
            if_resp_data = mem2proc_data;
        end
        if (dc_resp_valid) begin
            dc_resp_addr = tbl_addr[mem2proc_data_tag];
            dc_resp_data = mem2proc_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tbl_valid <= '0;
            tbl_is_if <= '0;
            tbl_stale <= '0;
            wait_cnt  <= '0;
        end else begin
            if (squash)
                tbl_stale <= tbl_stale | (tbl_valid & tbl_is_if);
            if (rsp_hit)
                tbl_valid[mem2proc_data_tag] <= 1'b0;
            // NOTE: the last non-blocking write to a bit wins, so an allocate to the tag
            // being retired this cycle overrides the clear above.
            if (alloc) begin
                tbl_valid[mem2proc_transaction_tag] <= 1'b1;
                tbl_is_if[mem2proc_transaction_tag] <= if_grant;
                tbl_stale[mem2proc_transaction_tag] <= squash && if_grant;
            end
            if (!if_req_valid || if_req_accept)
                wait_cnt <= '0;
            else if (!if_grant && !wait_sat)
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // NOTE: the address store is qualified by tbl_valid, so it carries no reset.
    always_ff @(posedge clock) begin
        if (alloc)
            tbl_addr[mem2proc_transaction_tag] <= alloc_addr;
    end

`ifdef MEM_ARB_STATS_EN
    logic rsp_drop;
    assign rsp_drop = rsp_hit && rsp_is_if && rsp_stale;

    always_ff @(posedge clock) begin
        if (reset) begin
            if_grant_cnt   <= '0;
            dc_grant_cnt   <= '0;
            stale_drop_cnt <= '0;
        end else begin
            if (if_req_accept) if_grant_cnt   <= if_grant_cnt + 32'd1;
            if (dc_req_accept) dc_grant_cnt   <= dc_grant_cnt + 32'd1;
            if (rsp_drop)      stale_drop_cnt <= stale_drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TAG_W    = 4;
    localparam int MAX_WAIT = 4;
    localparam int NT       = 2 ** TAG_W;

    logic              clock = 1'b0;
    logic              reset, squash;
    logic              if_req_valid, if_req_accept, if_resp_valid;
    logic [31:0]       if_req_addr, if_resp_addr;
    logic [63:0]       if_resp_data;
    logic              dc_req_valid, dc_req_store, dc_req_accept, dc_resp_valid;
    logic [31:0]       dc_req_addr, dc_resp_addr;
    logic [63:0]       dc_req_data, dc_resp_data;
    logic [1:0]        proc2mem_command;
    logic [31:0]       proc2mem_addr;
    logic [63:0]       proc2mem_data;
    logic [TAG_W-1:0]  mem2proc_transaction_tag, mem2proc_data_tag;
    logic [63:0]       mem2proc_data;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]       if_grant_cnt, dc_grant_cnt, stale_drop_cnt;
`endif

    always #5 clock = ~clock;

    mem_arbiter #(.TAG_W(TAG_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_accept(if_req_accept),
        .if_resp_valid(if_resp_valid), .if_resp_addr(if_resp_addr), .if_resp_data(if_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_store(dc_req_store), .dc_req_addr(dc_req_addr),
        .dc_req_data(dc_req_data), .dc_req_accept(dc_req_accept),
        .dc_resp_valid(dc_resp_valid), .dc_resp_addr(dc_resp_addr), .dc_resp_data(dc_resp_data),
`ifdef MEM_ARB_STATS_EN
        .if_grant_cnt(if_grant_cnt), .dc_grant_cnt(dc_grant_cnt), .stale_drop_cnt(stale_drop_cnt),
`endif
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .mem2proc_transaction_tag(mem2proc_transaction_tag),
        .mem2proc_data(mem2proc_data), .mem2proc_data_tag(mem2proc_data_tag)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: one record per outstanding memory transaction.
    typedef struct {
        bit          live;
        bit          fetch;
        bit          stale;
        logic [31:0] addr;
    } txn_t;

    txn_t book[NT];
    int   fetch_losses;
    bit   last_if_acc, last_dc_acc;
    int   exp_if_grants, exp_dc_grants, exp_drops;

    function automatic bit fetch_turn();
        return if_req_valid && (!dc_req_valid || fetch_losses >= MAX_WAIT);
    endfunction

    function automatic bit dc_turn();
        return dc_req_valid && !fetch_turn();
    endfunction

    task automatic sample();
        bit          f, d, taken, hit;
        int          t;
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        @(negedge clock);
        f      = fetch_turn();
        d      = dc_turn();
        taken  = (mem2proc_transaction_tag != 0);
        e_cmd  = f ? 2'd1 : (d ? (dc_req_store ? 2'd2 : 2'd1) : 2'd0);
        e_addr = f ? if_req_addr : (d ? dc_req_addr : 32'd0);
        e_data = (!f && d) ? dc_req_data : 64'd0;
        check("cmd", 64'(proc2mem_command), 64'(e_cmd));
        check("mem_addr", 64'(proc2mem_addr), 64'(e_addr));
        check("mem_data", proc2mem_data, e_data);
        check("if_accept", 64'(if_req_accept), 64'(f && taken));
        check("dc_accept", 64'(dc_req_accept), 64'(d && taken));
        t   = int'(mem2proc_data_tag);
        hit = (t != 0) && book[t].live;
        check("if_resp_valid", 64'(if_resp_valid), 64'(hit && book[t].fetch && !book[t].stale && !squash));
        check("dc_resp_valid", 64'(dc_resp_valid), 64'(hit && !book[t].fetch));
        check("if_resp_addr", 64'(if_resp_addr),
              (hit && book[t].fetch && !book[t].stale && !squash) ? 64'(book[t].addr) : 64'd0);
        check("if_resp_data", if_resp_data,
              (hit && book[t].fetch && !book[t].stale && !squash) ? mem2proc_data : 64'd0);
        check("dc_resp_addr", 64'(dc_resp_addr), (hit && !book[t].fetch) ? 64'(book[t].addr) : 64'd0);
        check("dc_resp_data", dc_resp_data, (hit && !book[t].fetch) ? mem2proc_data : 64'd0);
    endtask

    task automatic advance();
        bit f, d, taken, hit, drop;
        int t, a;
        @(posedge clock);
        f     = fetch_turn();
        d     = dc_turn();
        taken = (mem2proc_transaction_tag != 0);
        t     = int'(mem2proc_data_tag);
        a     = int'(mem2proc_transaction_tag);
        hit   = (t != 0) && book[t].live;
        drop  = hit && book[t].fetch && (book[t].stale || squash);
        last_if_acc = !reset && f && taken;
        last_dc_acc = !reset && d && taken;
        if (reset) begin
            foreach (book[i]) book[i].live = 1'b0;
            fetch_losses  = 0;
            exp_if_grants = 0;
            exp_dc_grants = 0;
            exp_drops     = 0;
        end else begin
            if (squash)
                foreach (book[i]) if (book[i].live && book[i].fetch) book[i].stale = 1'b1;
            if (hit) book[t].live = 1'b0;
            if (f && taken)
                book[a] = '{live: 1'b1, fetch: 1'b1, stale: squash, addr: if_req_addr};
            else if (d && taken && !dc_req_store)
                book[a] = '{live: 1'b1, fetch: 1'b0, stale: 1'b0, addr: dc_req_addr};
            if (!if_req_valid || (f && taken)) fetch_losses = 0;
            else if (!f) fetch_losses = (fetch_losses >= MAX_WAIT) ? MAX_WAIT : fetch_losses + 1;
            exp_if_grants += (f && taken) ? 1 : 0;
            exp_dc_grants += (d && taken) ? 1 : 0;
            exp_drops     += drop ? 1 : 0;
        end
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic idle();
        reset = 0; squash = 0;
        if_req_valid = 0; if_req_addr = '0;
        dc_req_valid = 0; dc_req_store = 0; dc_req_addr = '0; dc_req_data = '0;
        mem2proc_transaction_tag = '0; mem2proc_data = '0; mem2proc_data_tag = '0;
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
        sample();
        check("rst_cmd", 64'(proc2mem_command), 64'd0);
        check("rst_if_resp", 64'(if_resp_valid), 64'd0);
        check("rst_dc_resp", 64'(dc_resp_valid), 64'd0);
        advance();

        // Lone fetch, response five cycles later.
        if_req_valid = 1; if_req_addr = 32'h100; mem2proc_transaction_tag = 4'd3;
        sample(); check("s1_accept", 64'(if_req_accept), 64'd1); advance();
        idle();
        repeat (4) step();
        mem2proc_data_tag = 4'd3; mem2proc_data = 64'hDEAD;
        sample();
        check("s1_resp_valid", 64'(if_resp_valid), 64'd1);
        check("s1_resp_addr", 64'(if_resp_addr), 64'h100);
        check("s1_resp_data", if_resp_data, 64'hDEAD);
        advance();
        idle();

        // Contention: dcache wins four times, then fetch is forced through.
        if_req_valid = 1; if_req_addr = 32'h240;
        dc_req_valid = 1; dc_req_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            mem2proc_transaction_tag = 4'(8 + i);
            sample();
            check("s2_dc_accept", 64'(dc_req_accept), 64'(i != 4));
            check("s2_if_accept", 64'(if_req_accept), 64'(i == 4));
            advance();
        end
        idle();

        // Squash while a fetch is outstanding.
        if_req_valid = 1; if_req_addr = 32'h300; mem2proc_transaction_tag = 4'd5;
        step();
        idle(); step();
        squash = 1; step();
        idle(); mem2proc_data_tag = 4'd5; mem2proc_data = 64'h1234;
        sample(); check("s3_dropped", 64'(if_resp_valid), 64'd0); advance();
        sample(); check("s3_freed", 64'(if_resp_valid | dc_resp_valid), 64'd0); advance();
        idle();

        // Store allocates nothing.
        dc_req_valid = 1; dc_req_store = 1; dc_req_addr = 32'h400; dc_req_data = 64'hBEEF;
        mem2proc_transaction_tag = 4'd7;
        sample();
        check("s4_cmd", 64'(proc2mem_command), 64'd2);
        check("s4_data", proc2mem_data, 64'hBEEF);
        check("s4_accept", 64'(dc_req_accept), 64'd1);
        advance();
        idle(); mem2proc_data_tag = 4'd7;
        sample(); check("s4_no_resp", 64'(dc_resp_valid), 64'd0); advance();
        idle();

        // Memory rejects, fetch retries.
        if_req_valid = 1; if_req_addr = 32'h500; mem2proc_transaction_tag = 4'd0;
        sample();
        check("s5_reject", 64'(if_req_accept), 64'd0);
        check("s5_cmd", 64'(proc2mem_command), 64'd1);
        advance();
        mem2proc_transaction_tag = 4'd6;
        sample(); check("s5_retry", 64'(if_req_accept), 64'd1); advance();
        idle();

        // Response and new allocate on the same tag.
        dc_req_valid = 1; dc_req_addr = 32'h600; mem2proc_transaction_tag = 4'd4;
        step();
        idle(); if_req_valid = 1; if_req_addr = 32'h640;
        mem2proc_transaction_tag = 4'd4; mem2proc_data_tag = 4'd4; mem2proc_data = 64'h55;
        sample(); check("s7_dc_resp", 64'(dc_resp_valid), 64'd1); advance();
        idle(); mem2proc_data_tag = 4'd4; mem2proc_data = 64'h66;
        sample();
        check("s7_if_resp", 64'(if_resp_valid), 64'd1);
        check("s7_if_addr", 64'(if_resp_addr), 64'h640);
        advance();
        idle();

`ifdef MEM_ARB_STATS_EN
        sample();
        check("stat_if", 64'(if_grant_cnt), 64'(exp_if_grants));
        check("stat_dc", 64'(dc_grant_cnt), 64'(exp_dc_grants));
        check("stat_drop", 64'(stale_drop_cnt), 64'(exp_drops));
        advance();
`endif

        // Reset discards outstanding tags.
        if_req_valid = 1; if_req_addr = 32'h700; mem2proc_transaction_tag = 4'd2; step();
        idle(); dc_req_valid = 1; dc_req_addr = 32'h740; mem2proc_transaction_tag = 4'd9; step();
        idle(); reset = 1; step();
        idle(); mem2proc_data_tag = 4'd2;
        sample(); check("s6_tag2", 64'(if_resp_valid | dc_resp_valid), 64'd0); advance();
        mem2proc_data_tag = 4'd9;
        sample(); check("s6_tag9", 64'(if_resp_valid | dc_resp_valid), 64'd0); advance();
        idle();

        // Randomized traffic; requesters hold their payload until accepted.
        for (int c = 0; c < 600; c++) begin
            if (!if_req_valid || last_if_acc) begin
                if_req_valid = ($urandom_range(9) < 6);
                if_req_addr  = {$urandom_range(255), 3'b000};
            end
            if (!dc_req_valid || last_dc_acc) begin
                dc_req_valid = ($urandom_range(9) < 6);
                dc_req_store = $urandom_range(1);
                dc_req_addr  = {$urandom_range(255), 3'b000};
                dc_req_data  = {$urandom, $urandom};
            end
            squash = ($urandom_range(99) < 8);
            reset  = ($urandom_range(99) < 2);
            mem2proc_transaction_tag = ($urandom_range(3) == 0) ? '0 : 4'($urandom_range(NT - 1, 1));
            mem2proc_data_tag        = ($urandom_range(1) == 0) ? '0 : 4'($urandom_range(NT - 1, 1));
            mem2proc_data            = {$urandom, $urandom};
            step();
        end
        idle();

`ifdef MEM_ARB_STATS_EN
        sample();
        check("stat_if_rand", 64'(if_grant_cnt), 64'(exp_if_grants));
        check("stat_dc_rand", 64'(dc_grant_cnt), 64'(exp_dc_grants));
        check("stat_drop_rand", 64'(stale_drop_cnt), 64'(exp_drops));
        advance();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
